// File: rtl/universal_shift_register.sv
// -----------------------------------------------------------------------------
// universal_shift_register
//
// Parametrised universal shift register for the lab top-level. It supports
// hold, shift right, shift left and parallel load. Shifts can either
// recirculate the outgoing bit (rotate) or insert serial_in. The register
// also provides a registered serial output, a saturating shift counter with a
// full flag, and a hex 7-segment decode of the low nibble.
//
// Parameters:
//   NBITS        register width, legal range 4..32
//   NCNT         shift counter width, derived from NBITS (leave at default)
//
// Ports:
//   clk_2        in   1      system clock, rising-edge active
//   reset        in   1      asynchronous active-low reset
//   en           in   1      operation enable; all state holds when low
//   mode         in   2      00 hold, 01 shift right, 10 shift left, 11 load
//   rotate       in   1      1: shifts recirculate the outgoing bit
//   serial_in    in   1      bit inserted on non-rotating shifts
//   parallel_in  in   NBITS  data loaded in mode 11
//   q            out  NBITS  register contents
//   serial_out   out  1      last bit shifted/rotated out (registered)
//   shift_count  out  NCNT   shifts since last load/reset, saturates at NBITS
//   count_full   out  1      shift_count == NBITS
//   seg          out  8      7-seg pattern of q[3:0] (g..a), bit7 = count_full
// -----------------------------------------------------------------------------
module universal_shift_register #(
  parameter int NBITS = 8,
  parameter int NCNT  = $clog2(NBITS + 1)
) (
  input  logic             clk_2,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             rotate,
  input  logic             serial_in,
  input  logic [NBITS-1:0] parallel_in,
  output logic [NBITS-1:0] q,
  output logic             serial_out,
  output logic [NCNT-1:0]  shift_count,
  output logic             count_full,
  output logic [7:0]       seg
);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  localparam logic [NCNT-1:0] CNT_FULL = NCNT'(NBITS);
  localparam logic [NCNT-1:0] CNT_ONE  = NCNT'(1);

  logic [NBITS-1:0] q_reg, q_next;
  logic             so_reg, so_next;
  logic [NCNT-1:0]  cnt_reg, cnt_next;
  logic             in_bit;
  logic             full;
  logic [6:0]       seg7;

  assign full = (cnt_reg == CNT_FULL);

  // Next-state logic. The counter saturates rather than wraps so that the
  // full flag stays asserted until the next load or reset.
  always_comb begin
    q_next   = q_reg;
    so_next  = so_reg;
    cnt_next = cnt_reg;
    in_bit   = serial_in;
    if (en) begin
      case (mode)
        MODE_RIGHT: begin
          in_bit   = rotate ? q_reg[0] : serial_in;
          q_next   = {in_bit, q_reg[NBITS-1:1]};
          so_next  = q_reg[0];
          cnt_next = full ? cnt_reg : cnt_reg + CNT_ONE;
        end
        MODE_LEFT: begin
          in_bit   = rotate ? q_reg[NBITS-1] : serial_in;
          q_next   = {q_reg[NBITS-2:0], in_bit};
          so_next  = q_reg[NBITS-1];
          cnt_next = full ? cnt_reg : cnt_reg + CNT_ONE;
        end
        MODE_LOAD: begin
          // serial_out deliberately keeps its last shifted-out bit.
          q_next   = parallel_in;
          cnt_next = '0;
        end
        MODE_HOLD: ;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_2 or negedge reset) begin
    if (!reset) begin
      q_reg   <= '0;
      so_reg  <= 1'b0;
      cnt_reg <= '0;
    end else begin
      q_reg   <= q_next;
      so_reg  <= so_next;
      cnt_reg <= cnt_next;
    end
  end

  // Hex decode of the low nibble, segments g..a in bits 6..0.
  always_comb begin
    seg7 = 7'h3F;
    case (q_reg[3:0])
      4'h0: seg7 = 7'h3F;
      4'h1: seg7 = 7'h06;
      4'h2: seg7 = 7'h5B;
      4'h3: seg7 = 7'h4F;
      4'h4: seg7 = 7'h66;
      4'h5: seg7 = 7'h6D;
      4'h6: seg7 = 7'h7D;
      4'h7: seg7 = 7'h07;
      4'h8: seg7 = 7'h7F;
      4'h9: seg7 = 7'h6F;
      4'hA: seg7 = 7'h77;
      4'hB: seg7 = 7'h7C;
      4'hC: seg7 = 7'h39;
      4'hD: seg7 = 7'h5E;
      4'hE: seg7 = 7'h79;
      4'hF: seg7 = 7'h71;
      default: seg7 = 7'h3F;
    endcase
  end

  assign q           = q_reg;
  assign serial_out  = so_reg;
  assign shift_count = cnt_reg;
  assign count_full  = full;
  assign seg         = {full, seg7};

endmodule
